// File: rtl/fft_sdiv_24s_8s_16_seq.sv
// Sequential 24s/8s signed divider with a saturated 16-bit quotient and a C-style remainder.
// Uses restoring division on magnitudes, then applies signs, saturation and divide-by-zero rules.
module fft_sdiv_24s_8s_16_seq #(
  parameter int din0_WIDTH = 24,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] dividend,
  input  logic [din1_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quotient,
  output logic [din1_WIDTH-1:0] remainder,
  output logic                  ovf,
  output logic                  dbz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state;
  logic [4:0]            cnt;
  logic                  go;
  logic [din0_WIDTH-1:0] ad;
  logic [din1_WIDTH-1:0] dv;
  logic [8:0]            pr;
  logic                  sign_q;
  logic                  sign_r;
  logic                  zero_d;

  logic [9:0]            diff;
  logic                  fits;
  logic [dout_WIDTH-1:0] q_fix;
  logic [din1_WIDTH-1:0] r_fix;
  logic                  ovf_fix;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The partial remainder never exceeds 127, so the shifted value fits in 9 bits
  // and bit 9 of the difference is a reliable borrow flag.
  assign diff = {pr, ad[23]} - {2'b00, dv};
  assign fits = ~diff[9];

  always_comb begin
    q_fix   = ad[15:0];
    r_fix   = sign_r ? (8'd0 - pr[7:0]) : pr[7:0];
    ovf_fix = 1'b0;
    if (zero_d) begin
      q_fix = sign_r ? 16'h8000 : 16'h7FFF;
      r_fix = 8'd0;
    end else if (!sign_q && (ad > 24'd32767)) begin
      q_fix   = 16'h7FFF;
      ovf_fix = 1'b1;
    end else if (sign_q && (ad > 24'd32768)) begin
      q_fix   = 16'h8000;
      ovf_fix = 1'b1;
    end else if (sign_q) begin
      q_fix = 16'd0 - ad[15:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      go        <= 1'b0;
      ad        <= '0;
      dv        <= '0;
      pr        <= 9'd0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_d    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ad     <= dividend[23] ? (24'd0 - dividend) : dividend;
            dv     <= divisor[7] ? (8'd0 - divisor) : divisor;
            sign_q <= dividend[23] ^ divisor[7];
            sign_r <= dividend[23];
            zero_d <= (divisor == 8'd0);
            pr     <= 9'd0;
            cnt    <= 5'd0;
            go     <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          // first CALC cycle is a settle slot so results land 26 cycles after acceptance
          if (!go) begin
            go <= 1'b1;
          end else begin
            pr  <= fits ? diff[8:0] : {pr[7:0], ad[23]};
            ad  <= {ad[22:0], fits};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd23) begin
              cnt   <= 5'd0;
              state <= FIX;
            end
          end
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_fix;
          dbz       <= zero_d;
          state     <= DONE;
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule
